// File: rtl/charge_session_ctrl.sv
// charge_session_ctrl: coin-operated charger session controller.
// Accepts coin pulses up to 20 units, converts the paid amount into charge
// time (2 units per coin unit), counts it down on a one-second tick and holds
// a DONE indication before returning to IDLE.
// Optional feature macro: CHARGER_TIMEOUT_EN -- abandons an idle INSERT
// session after TIMEOUT_S seconds and pulses refund.
module charge_session_ctrl #(
  parameter int unsigned TICK_DIV    = 50_000_000,
  parameter int unsigned TIMEOUT_S   = 10,
  parameter int unsigned DONE_HOLD_S = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       coin_1,
  input  logic       coin_10,
  input  logic       start,
  input  logic       stop,
  output logic [4:0] all_money,
  output logic [5:0] remaining_time,
  output logic       charging,
  output logic       done,
  output logic       reject,
  output logic       refund
);

  localparam int unsigned PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SEC_MAX = (TIMEOUT_S > DONE_HOLD_S) ? TIMEOUT_S : DONE_HOLD_S;
  localparam int unsigned SW      = (SEC_MAX > 1) ? $clog2(SEC_MAX) : 1;
  localparam logic [5:0]  MONEY_MAX = 6'd20;

  typedef enum logic [1:0] {
    S_IDLE,
    S_INSERT,
    S_CHARGE,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [4:0]      money_q, money_d;
  logic [5:0]      time_q, time_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [SW-1:0]   sec_q, sec_d;
  logic            charging_q, charging_d;
  logic            done_q, done_d;
  logic            reject_q, reject_d;

  logic            tick;
  logic            coin_any;
  logic [3:0]      add;
  logic [5:0]      sum6;
  logic            fits;

  // Coin value and the widened running total used for the acceptance compare.
  always_comb begin
    coin_any = coin_1 | coin_10;
    add      = (coin_10 ? 4'd10 : 4'd0) + {3'b000, coin_1};
    sum6     = {1'b0, money_q} + {2'b00, add};
    fits     = (sum6 <= MONEY_MAX);
    tick     = (presc_q == PW'(TICK_DIV - 1));
  end

`ifdef CHARGER_TIMEOUT_EN
  logic refund_q, refund_d;
`endif

  // Session state machine: next state, money/time datapath and pulse outputs.
  always_comb begin
    state_d  = state_q;
    money_d  = money_q;
    time_d   = time_q;
    presc_d  = tick ? '0 : presc_q + PW'(1);
    sec_d    = sec_q;
    reject_d = 1'b0;
`ifdef CHARGER_TIMEOUT_EN
    refund_d = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        money_d = '0;
        time_d  = '0;
        // From zero any single-cycle coin combination (max 11) fits.
        if (coin_any) begin
          state_d = S_INSERT;
          money_d = sum6[4:0];
          time_d  = sum6 + sum6;
        end
      end

      S_INSERT: begin
        if (coin_any && fits) begin
          money_d = sum6[4:0];
          time_d  = sum6 + sum6;
          presc_d = '0;
          sec_d   = '0;
        end else begin
          // A coin in the same cycle masks start, even when it is refused.
          if (coin_any) begin
            reject_d = 1'b1;
          end else if (start && (money_q != '0)) begin
            state_d = S_CHARGE;
          end
`ifdef CHARGER_TIMEOUT_EN
          if ((state_d == S_INSERT) && tick) begin
            if (sec_q == SW'(TIMEOUT_S - 1)) begin
              state_d  = S_IDLE;
              money_d  = '0;
              time_d   = '0;
              refund_d = 1'b1;
            end else begin
              sec_d = sec_q + SW'(1);
            end
          end
`endif
        end
      end

      S_CHARGE: begin
        if (coin_any) begin
          reject_d = 1'b1;
        end
        if (stop) begin
          state_d = S_DONE;
          money_d = '0;
          time_d  = '0;
        end else if (tick) begin
          if (time_q <= 6'd1) begin
            state_d = S_DONE;
            money_d = '0;
            time_d  = '0;
          end else begin
            time_d = time_q - 6'd1;
          end
        end
      end

      S_DONE: begin
        money_d = '0;
        time_d  = '0;
        if (coin_any) begin
          reject_d = 1'b1;
        end
        if (tick) begin
          if (sec_q == SW'(DONE_HOLD_S - 1)) begin
            state_d = S_IDLE;
          end else begin
            sec_d = sec_q + SW'(1);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        money_d = '0;
        time_d  = '0;
      end
    endcase

    // Every transition restarts both the prescaler and the seconds count.
    if (state_d != state_q) begin
      presc_d = '0;
      sec_d   = '0;
    end

    charging_d = (state_d == S_CHARGE);
    done_d     = (state_d == S_DONE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      money_q    <= '0;
      time_q     <= '0;
      presc_q    <= '0;
      sec_q      <= '0;
      charging_q <= 1'b0;
      done_q     <= 1'b0;
      reject_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      money_q    <= money_d;
      time_q     <= time_d;
      presc_q    <= presc_d;
      sec_q      <= sec_d;
      charging_q <= charging_d;
      done_q     <= done_d;
      reject_q   <= reject_d;
    end
  end

`ifdef CHARGER_TIMEOUT_EN
  // Refund pulse register for abandoned INSERT sessions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refund_q <= 1'b0;
    end else begin
      refund_q <= refund_d;
    end
  end

  assign refund = refund_q;
`else
  assign refund = 1'b0;
`endif

  assign all_money      = money_q;
  assign remaining_time = time_q;
  assign charging       = charging_q;
  assign done           = done_q;
  assign reject         = reject_q;

endmodule

// File: tb/tb_charge_session_ctrl.sv
// Self-checking bench for charge_session_ctrl (TICK_DIV=4, TIMEOUT_S=3,
// DONE_HOLD_S=2). Expected output vectors are queued as stimulus is driven
// and compared one cycle later by a monitor.
// Vector layout: {all_money[4:0], remaining_time[5:0], charging, done, reject, refund}.
module tb_charge_session_ctrl;

  logic       clk;
  logic       rst_n;
  logic       coin_1;
  logic       coin_10;
  logic       start;
  logic       stop;
  logic [4:0] all_money;
  logic [5:0] remaining_time;
  logic       charging;
  logic       done;
  logic       reject;
  logic       refund;

  int unsigned n_checks;
  int unsigned n_fail;

  logic [14:0] exp_q[$];
  string       tag_q[$];
  logic [14:0] outv;

  charge_session_ctrl #(
    .TICK_DIV   (4),
    .TIMEOUT_S  (3),
    .DONE_HOLD_S(2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .coin_1        (coin_1),
    .coin_10       (coin_10),
    .start         (start),
    .stop          (stop),
    .all_money     (all_money),
    .remaining_time(remaining_time),
    .charging      (charging),
    .done          (done),
    .reject        (reject),
    .refund        (refund)
  );

  assign outv = {all_money, remaining_time, charging, done, reject, refund};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [14:0] ev(input int m, input int t, input bit ch,
                                     input bit dn, input bit rj, input bit rf);
    return {5'(m), 6'(t), ch, dn, rj, rf};
  endfunction

  task automatic check_eq(input string tag, input logic [14:0] got, input logic [14:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got money=%0d time=%0d chg=%b done=%b rej=%b ref=%b exp money=%0d time=%0d chg=%b done=%b rej=%b ref=%b",
               tag, got[14:10], got[9:4], got[3], got[2], got[1], got[0],
               exp[14:10], exp[9:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Monitor: compare the DUT outputs after each edge with the queued expectation.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      check_eq(tag_q.pop_front(), outv, exp_q.pop_front());
    end
  end

  task automatic step(input string tag, input bit c1, input bit c10, input bit st,
                      input bit sp, input logic [14:0] e);
    @(negedge clk);
    coin_1  = c1;
    coin_10 = c10;
    start   = st;
    stop    = sp;
    tag_q.push_back(tag);
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  // Called on the cycle after DONE entry: 7 more DONE cycles, then IDLE.
  task automatic finish_done(input string tag);
    step({tag, "_done_coin"}, 1'b0, 1'b1, 1'b0, 1'b0, ev(0, 0, 0, 1, 1, 0));
    step({tag, "_done_start"}, 1'b0, 1'b0, 1'b1, 1'b0, ev(0, 0, 0, 1, 0, 0));
    step({tag, "_done_stop"}, 1'b0, 1'b0, 1'b0, 1'b1, ev(0, 0, 0, 1, 0, 0));
    for (int j = 4; j <= 7; j++)
      step({tag, "_done_hold"}, 1'b0, 1'b0, 1'b0, 1'b0, ev(0, 0, 0, 1, 0, 0));
    step({tag, "_idle"}, 1'b0, 1'b0, 1'b0, 1'b0, ev(0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    coin_1   = 1'b0;
    coin_10  = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_state", outv, ev(0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;

    // Normal session: 10 + 1 -> 11 units, 22 time, 88 cycles of charge.
    step("n_coin10", 1'b0, 1'b1, 1'b0, 1'b0, ev(10, 20, 0, 0, 0, 0));
    step("n_coin1", 1'b1, 1'b0, 1'b0, 1'b0, ev(11, 22, 0, 0, 0, 0));
    step("n_start", 1'b0, 1'b0, 1'b1, 1'b0, ev(11, 22, 1, 0, 0, 0));
    for (int k = 1; k < 88; k++)
      step("n_charge", 1'b0, 1'b0, 1'b0, 1'b0, ev(11, 22 - k / 4, 1, 0, 0, 0));
    step("n_to_done", 1'b0, 1'b0, 1'b0, 1'b0, ev(0, 0, 0, 1, 0, 0));
    finish_done("n");

    // Saturation at 20 and combined-coin handling.
    step("s_c10a", 1'b0, 1'b1, 1'b0, 1'b0, ev(10, 20, 0, 0, 0, 0));
    step("s_c10b", 1'b0, 1'b1, 1'b0, 1'b0, ev(20, 40, 0, 0, 0, 0));
    step("s_over", 1'b1, 1'b0, 1'b0, 1'b0, ev(20, 40, 0, 0, 1, 0));
    step("s_rej_clr", 1'b0, 1'b0, 1'b0, 1'b0, ev(20, 40, 0, 0, 0, 0));
    step("s_start", 1'b0, 1'b0, 1'b1, 1'b0, ev(20, 40, 1, 0, 0, 0));
    step("s_stop", 1'b0, 1'b0, 1'b0, 1'b1, ev(0, 0, 0, 1, 0, 0));
    finish_done("s");
    step("s_both_idle", 1'b1, 1'b1, 1'b0, 1'b0, ev(11, 22, 0, 0, 0, 0));
    for (int m = 12; m <= 15; m++)
      step("s_fill", 1'b1, 1'b0, 1'b0, 1'b0, ev(m, 2 * m, 0, 0, 0, 0));
    step("s_both_over", 1'b1, 1'b1, 1'b0, 1'b0, ev(15, 30, 0, 0, 1, 0));
    step("s_hold15", 1'b0, 1'b0, 1'b0, 1'b0, ev(15, 30, 0, 0, 0, 0));

    // Abort: stop on the tick cycle while remaining_time is 7.
    step("a_start", 1'b0, 1'b0, 1'b1, 1'b0, ev(15, 30, 1, 0, 0, 0));
    for (int k = 1; k <= 95; k++) begin
      if (k == 10)
        step("a_coin_rej", 1'b1, 1'b0, 1'b0, 1'b0, ev(15, 30 - k / 4, 1, 0, 1, 0));
      else
        step("a_charge", 1'b0, 1'b0, 1'b0, 1'b0, ev(15, 30 - k / 4, 1, 0, 0, 0));
    end
    step("a_stop_tick", 1'b0, 1'b0, 1'b0, 1'b1, ev(0, 0, 0, 1, 0, 0));
    finish_done("a");

    // Precedence: start/stop ignored in IDLE, coin beats start in INSERT.
    step("p_start_idle", 1'b0, 1'b0, 1'b1, 1'b0, ev(0, 0, 0, 0, 0, 0));
    step("p_stop_idle", 1'b0, 1'b0, 1'b0, 1'b1, ev(0, 0, 0, 0, 0, 0));
    for (int m = 1; m <= 5; m++)
      step("p_coin", 1'b1, 1'b0, 1'b0, 1'b0, ev(m, 2 * m, 0, 0, 0, 0));
    step("p_coin_start", 1'b1, 1'b0, 1'b1, 1'b0, ev(6, 12, 0, 0, 0, 0));
    step("p_stay_insert", 1'b0, 1'b0, 1'b0, 1'b0, ev(6, 12, 0, 0, 0, 0));
    step("p_start", 1'b0, 1'b0, 1'b1, 1'b0, ev(6, 12, 1, 0, 0, 0));
    step("p_stop", 1'b0, 1'b0, 1'b0, 1'b1, ev(0, 0, 0, 1, 0, 0));
    finish_done("p");

    // Timeout behaviour in INSERT; an accepted coin restarts the count.
    step("t_coin1", 1'b1, 1'b0, 1'b0, 1'b0, ev(1, 2, 0, 0, 0, 0));
    for (int k = 1; k <= 5; k++)
      step("t_quiet_a", 1'b0, 1'b0, 1'b0, 1'b0, ev(1, 2, 0, 0, 0, 0));
    step("t_coin2", 1'b1, 1'b0, 1'b0, 1'b0, ev(2, 4, 0, 0, 0, 0));
    for (int k = 1; k <= 11; k++)
      step("t_quiet_b", 1'b0, 1'b0, 1'b0, 1'b0, ev(2, 4, 0, 0, 0, 0));
`ifdef CHARGER_TIMEOUT_EN
    step("t_refund", 1'b0, 1'b0, 1'b0, 1'b0, ev(0, 0, 0, 0, 0, 1));
    step("t_idle", 1'b0, 1'b0, 1'b0, 1'b0, ev(0, 0, 0, 0, 0, 0));
`else
    step("t_no_timeout", 1'b0, 1'b0, 1'b0, 1'b0, ev(2, 4, 0, 0, 0, 0));
    step("t_still_insert", 1'b0, 1'b0, 1'b0, 1'b0, ev(2, 4, 0, 0, 0, 0));
    step("t_start", 1'b0, 1'b0, 1'b1, 1'b0, ev(2, 4, 1, 0, 0, 0));
    step("t_stop", 1'b0, 1'b0, 1'b0, 1'b1, ev(0, 0, 0, 1, 0, 0));
    finish_done("t");
`endif

    // Asynchronous reset in the middle of CHARGE.
    step("r_coin10", 1'b0, 1'b1, 1'b0, 1'b0, ev(10, 20, 0, 0, 0, 0));
    step("r_start", 1'b0, 1'b0, 1'b1, 1'b0, ev(10, 20, 1, 0, 0, 0));
    for (int k = 1; k <= 3; k++)
      step("r_charge", 1'b0, 1'b0, 1'b0, 1'b0, ev(10, 20, 1, 0, 0, 0));
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("r_async_clear", outv, ev(0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    check_eq("r_held", outv, ev(0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    step("r_after_a", 1'b0, 1'b0, 1'b0, 1'b0, ev(0, 0, 0, 0, 0, 0));
    step("r_after_b", 1'b0, 1'b0, 1'b0, 1'b0, ev(0, 0, 0, 0, 0, 0));

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
